// File: rtl/sdp_x_alu_out_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sdp_x_alu_out_arb_if
// Purpose  : Bundles the two ALU lane request streams and the shared output
//            stream of the SDP ALU output arbiter.
// Signals  : req0_vld/req0_rdy/req0_pd  lane 0 request handshake + payload
//            req1_vld/req1_rdy/req1_pd  lane 1 request handshake + payload
//            out_vld/out_rdy/out_pd     arbitrated output handshake + payload
//            out_src                    lane that produced out_pd
// Modports : master - the arbiter (drives rdy's and the output stream)
//            slave  - the environment (lanes and downstream consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface sdp_x_alu_out_arb_if #(
  parameter int DATA_W = 32
);
  logic              req0_vld;
  logic              req0_rdy;
  logic [DATA_W-1:0] req0_pd;
  logic              req1_vld;
  logic              req1_rdy;
  logic [DATA_W-1:0] req1_pd;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_pd;
  logic              out_src;

  modport master (
    input  req0_vld, req0_pd, req1_vld, req1_pd, out_rdy,
    output req0_rdy, req1_rdy, out_vld, out_pd, out_src
  );

  modport slave (
    output req0_vld, req0_pd, req1_vld, req1_pd, out_rdy,
    input  req0_rdy, req1_rdy, out_vld, out_pd, out_src
  );
endinterface
`default_nettype wire

// File: rtl/sdp_x_alu_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdp_x_alu_out_arb
// Purpose  : Two-lane round-robin arbiter sharing the SDP ALU output stream.
//            One registered output stage (1-cycle latency, 1 word/cycle),
//            output held stable under backpressure, enable gate for new
//            grants and a saturating backpressure-cycle counter.
// Ports    : nvdla_core_clk   clock, rising edge
//            nvdla_core_rstn  asynchronous active-low reset
//            cfg_en           1 = new grants allowed
//            cfg_stall_clr    synchronous clear of stall_cnt
//            bus              request/output streams (master modport)
//            stall_cnt        saturating count of out_vld & !out_rdy cycles
// Revision : 1.0 - initial release
// ============================================================================
module sdp_x_alu_out_arb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire                     nvdla_core_clk,
  input  wire                     nvdla_core_rstn,
  input  wire                     cfg_en,
  input  wire                     cfg_stall_clr,
  sdp_x_alu_out_arb_if.master     bus,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_pd;
  logic              r_out_src;
  logic              r_last_gnt;   // 1 after reset so lane 0 wins first contention
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_slot_free;
  logic w_gnt0;
  logic w_gnt1;
  logic w_xfer0;
  logic w_xfer1;
  logic w_stall;

  // Slot is free when empty or when the held word leaves this cycle; this is
  // what lets a new word load in the same cycle the old one drains.
  assign w_slot_free = !r_out_vld || bus.out_rdy;
  assign w_stall     = r_out_vld && !bus.out_rdy;

  // Grant depends only on request valids, last winner and enable, so rdy
  // never has a combinational path from the output payload.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (cfg_en) begin
      if (bus.req0_vld && bus.req1_vld) begin
        w_gnt0 = r_last_gnt;
        w_gnt1 = !r_last_gnt;
      end else begin
        w_gnt0 = bus.req0_vld;
        w_gnt1 = bus.req1_vld;
      end
    end
  end

  assign bus.req0_rdy = w_gnt0 && w_slot_free;
  assign bus.req1_rdy = w_gnt1 && w_slot_free;

  assign w_xfer0 = w_gnt0 && bus.req0_vld && w_slot_free;
  assign w_xfer1 = w_gnt1 && bus.req1_vld && w_slot_free;

  // Output stage and priority pointer. Priority only rotates on an actual
  // transfer, so a granted-but-blocked lane keeps its turn.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_out_vld  <= 1'b0;
      r_out_pd   <= '0;
      r_out_src  <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      if (w_xfer0) begin
        r_out_vld  <= 1'b1;
        r_out_pd   <= bus.req0_pd;
        r_out_src  <= 1'b0;
        r_last_gnt <= 1'b0;
      end else if (w_xfer1) begin
        r_out_vld  <= 1'b1;
        r_out_pd   <= bus.req1_pd;
        r_out_src  <= 1'b1;
        r_last_gnt <= 1'b1;
      end else if (bus.out_rdy) begin
        // Held word (if any) drained with nothing to replace it; payload and
        // source are left as they were.
        r_out_vld <= 1'b0;
      end
    end
  end

  // Saturating stall counter; clear wins over a same-cycle increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_stall_cnt <= '0;
    end else if (cfg_stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.out_vld = r_out_vld;
  assign bus.out_pd  = r_out_pd;
  assign bus.out_src = r_out_src;
  assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdp_x_alu_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_x_alu_out_arb
// Purpose  : Self-checking bench for sdp_x_alu_out_arb. A reference model
//            predicts acceptances and pushes expected words into a queue; a
//            separate monitor pops and compares on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdp_x_alu_out_arb;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cfg_en = 1'b0;
  logic cfg_stall_clr = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  sdp_x_alu_out_arb_if #(.DATA_W(DATA_W)) bus ();

  sdp_x_alu_out_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .cfg_en         (cfg_en),
    .cfg_stall_clr  (cfg_stall_clr),
    .bus            (bus),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {src, pd} of each word the model expects to see delivered.
  logic [DATA_W:0] sb[$];

  // Reference-model state
  bit m_occ;        // output slot holds a word
  int m_last;       // lane that won most recently
  int m_cnt;        // expected stall counter
  bit acc0, acc1;   // lane accepted in the current cycle

  // Stimulus knobs (percent probabilities)
  int pv0, pv1, prdy, pen, pclr;
  bit seq_pd;
  int seq0, seq1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 1'b0;
    m_last = 1;
    m_cnt = 0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    sb.delete();
  endtask

  // Called mid-cycle with stable inputs: check registered state against the
  // model, then predict this cycle's acceptance and advance the model.
  task automatic model_cycle();
    bit free, e0, e1;
    chk("out_vld", {63'd0, bus.out_vld}, {63'd0, m_occ});
    chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
    free = !m_occ || bus.out_rdy;
    e0 = 1'b0;
    e1 = 1'b0;
    if (cfg_en && free) begin
      if (bus.req0_vld && bus.req1_vld) begin
        if (m_last == 1) e0 = 1'b1; else e1 = 1'b1;
      end else if (bus.req0_vld) e0 = 1'b1;
      else if (bus.req1_vld) e1 = 1'b1;
    end
    chk("req0_rdy", {63'd0, bus.req0_rdy}, {63'd0, e0});
    chk("req1_rdy", {63'd0, bus.req1_rdy}, {63'd0, e1});
    if (e0) begin sb.push_back({1'b0, bus.req0_pd}); m_last = 0; end
    if (e1) begin sb.push_back({1'b1, bus.req1_pd}); m_last = 1; end
    if (cfg_stall_clr) m_cnt = 0;
    else if (m_occ && !bus.out_rdy && m_cnt < CNT_MAX) m_cnt++;
    m_occ = e0 || e1 || (m_occ && !bus.out_rdy);
    acc0 = e0;
    acc1 = e1;
  endtask

  // Lanes hold vld/pd until accepted, then optionally raise a new word.
  task automatic drive();
    bus.out_rdy   = ($urandom_range(99) < prdy);
    cfg_en        = ($urandom_range(99) < pen);
    cfg_stall_clr = ($urandom_range(99) < pclr);
    if (!bus.req0_vld || acc0) begin
      bus.req0_vld = ($urandom_range(99) < pv0);
      if (bus.req0_vld) begin
        bus.req0_pd = seq_pd ? DATA_W'(32'h100 + seq0) : DATA_W'($urandom());
        seq0++;
      end
    end
    if (!bus.req1_vld || acc1) begin
      bus.req1_vld = ($urandom_range(99) < pv1);
      if (bus.req1_vld) begin
        bus.req1_pd = seq_pd ? DATA_W'(32'h200 + seq1) : DATA_W'($urandom());
        seq1++;
      end
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Monitor: compares every delivered word and checks hold stability.
  bit              held;
  logic [DATA_W:0] held_w;
  always @(negedge clk) begin
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", {31'd0, bus.out_src, bus.out_pd}, {31'd0, held_w});
      if (bus.out_vld && bus.out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {31'd0, bus.out_src, bus.out_pd}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [DATA_W:0] e;
          e = sb.pop_front();
          chk("out_word", {31'd0, bus.out_src, bus.out_pd}, {31'd0, e});
        end
        held = 1'b0;
      end else if (bus.out_vld) begin
        held = 1'b1;
        held_w = {bus.out_src, bus.out_pd};
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    bus.req0_vld = 1'b0; bus.req0_pd = '0;
    bus.req1_vld = 1'b0; bus.req1_pd = '0;
    bus.out_rdy = 1'b0;
    pv0 = 0; pv1 = 0; prdy = 100; pen = 100; pclr = 0;
    seq_pd = 1'b0; seq0 = 0; seq1 = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_vld", {63'd0, bus.out_vld}, 64'd0);
    chk("rst_out_pd", {32'd0, bus.out_pd}, 64'd0);
    chk("rst_out_src", {63'd0, bus.out_src}, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single word: 1-cycle latency, then idle
    cfg_en = 1'b1;
    bus.out_rdy = 1'b1;
    bus.req0_vld = 1'b1;
    bus.req0_pd = 32'hA5A5_0001;
    #1;
    chk("single_rdy0", {63'd0, bus.req0_rdy}, 64'd1);
    step();
    chk("single_out_vld", {63'd0, bus.out_vld}, 64'd1);
    chk("single_out_pd", {32'd0, bus.out_pd}, 64'hA5A5_0001);
    chk("single_out_src", {63'd0, bus.out_src}, 64'd0);
    step();
    chk("single_drained", {63'd0, bus.out_vld}, 64'd0);

    // Both lanes continuously valid, full throughput
    seq_pd = 1'b1; pv0 = 100; pv1 = 100; prdy = 100;
    drive();
    repeat (8) step();

    // Backpressure with both lanes valid, then resume
    prdy = 0;
    bus.out_rdy = 1'b0;
    repeat (5) step();
    prdy = 100;
    repeat (4) step();

    // Stall counter saturation, then clear in a stall cycle
    prdy = 0;
    bus.out_rdy = 1'b0;
    repeat (20) step();
    chk("stall_saturated", {60'd0, stall_cnt}, 64'(CNT_MAX));
    cfg_stall_clr = 1'b1;
    step();
    chk("stall_cleared", {60'd0, stall_cnt}, 64'd0);

    // Enable gate: held word drains, no new grants, then resume
    pen = 0; prdy = 100;
    cfg_en = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (3) step();
    chk("en_off_drained", {63'd0, bus.out_vld}, 64'd0);
    pen = 100;
    repeat (4) step();

    // Async reset mid-stream with a stalled word
    prdy = 0;
    bus.out_rdy = 1'b0;
    repeat (4) step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_vld", {63'd0, bus.out_vld}, 64'd0);
    chk("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    model_reset();
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    prdy = 100;
    drive();
    repeat (6) step();

    // Randomized traffic
    seq_pd = 1'b0;
    pv0 = 70; pv1 = 70; prdy = 60; pen = 90; pclr = 3;
    repeat (3000) step();

    // Drain
    pv0 = 0; pv1 = 0; prdy = 100; pen = 100; pclr = 0;
    repeat (5) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
